// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state codes,
// opcode/funct constants, ALU operation codes and the held control word.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        IC_RTYPE   = 3'd0,
        IC_LW      = 3'd1,
        IC_SW      = 3'd2,
        IC_BEQ     = 3'd3,
        IC_ADDI    = 3'd4,
        IC_ILLEGAL = 3'd5
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALUControl: bit 2 = M (invert B / subtract), bits 1:0 = S (result select)
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        iclass_e    iclass;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mips_main_decoder.sv
// Combinational instruction classifier: turns opcode/funct into a legality
// flag and the control word the FSM latches when leaving DECODE.
module mips_main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]        opcode_i,
    input  logic [5:0]        funct_i,
    output logic              legal_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    ctrl_t ctrl;

    always_comb begin
        ctrl        = '0;
        ctrl.iclass = IC_ILLEGAL;
        legal_o     = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                legal_o      = 1'b1;
                ctrl.iclass  = IC_RTYPE;
                ctrl.reg_dst = 1'b1;
                case (funct_i)
                    FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:  ctrl.alu_ctrl = ALU_AND;
                    FN_OR:   ctrl.alu_ctrl = ALU_OR;
                    FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
                    default: begin
                        // Unknown funct under op 0 traps like any bad opcode
                        legal_o      = 1'b0;
                        ctrl.iclass  = IC_ILLEGAL;
                        ctrl.reg_dst = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                legal_o         = 1'b1;
                ctrl.iclass     = IC_LW;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                legal_o       = 1'b1;
                ctrl.iclass   = IC_SW;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
            end
            OP_BEQ: begin
                legal_o       = 1'b1;
                ctrl.iclass   = IC_BEQ;
                ctrl.alu_ctrl = ALU_SUB;
            end
            OP_ADDI: begin
                legal_o       = 1'b1;
                ctrl.iclass   = IC_ADDI;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
            end
            default: ;
        endcase
    end

    assign ctrl_o = ctrl;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with held control word.
// Define MEM_WAIT_EN to stretch the MEM state until mem_ready is high.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       MemtoReg,
    output logic       Branch,
    output logic [2:0] ALUControl,
    output logic       pc_en,
    output logic       ir_en,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state
);

    state_e            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    ctrl_t             dec_ctrl;
    logic [CTRL_W-1:0] dec_ctrl_w;
    logic              dec_legal;
    logic              mem_done;

    mips_main_decoder u_decoder (
        .opcode_i (opcode),
        .funct_i  (funct),
        .legal_o  (dec_legal),
        .ctrl_o   (dec_ctrl_w)
    );

    assign dec_ctrl = ctrl_t'(dec_ctrl_w);

`ifdef MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        MemtoReg   = 1'b0;
        Branch     = 1'b0;
        ALUControl = 3'b000;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        // Held datapath controls are visible only while the instruction executes
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            RegDst     = ctrl_q.reg_dst;
            ALUSrc     = ctrl_q.alu_src;
            MemtoReg   = ctrl_q.mem_to_reg;
            ALUControl = ctrl_q.alu_ctrl;
        end

        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_en   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    ctrl_d  = dec_ctrl;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                end
            end
            ST_EXEC: begin
                case (ctrl_q.iclass)
                    IC_BEQ: begin
                        Branch     = 1'b1;
                        pc_en      = 1'b1;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    IC_LW, IC_SW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                MemWrite = (ctrl_q.iclass == IC_SW);
                MemRead  = (ctrl_q.iclass == IC_LW);
                if (mem_done) begin
                    if (ctrl_q.iclass == IC_LW) begin
                        state_d = ST_WB;
                    end else begin
                        pc_en      = 1'b1;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                RegWrite   = 1'b1;
                MemRead    = (ctrl_q.iclass == IC_LW);
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_TRAP: begin
                illegal    = 1'b1;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset silences every strobe in the same cycle so an abandoned
        // instruction can never write a register, memory or the PC.
        if (reset) begin
            RegDst     = 1'b0;
            RegWrite   = 1'b0;
            ALUSrc     = 1'b0;
            MemWrite   = 1'b0;
            MemRead    = 1'b0;
            MemtoReg   = 1'b0;
            Branch     = 1'b0;
            ALUControl = 3'b000;
            pc_en      = 1'b0;
            ir_en      = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle comparison of all
// outputs against a sequence model built from the instruction-class rules.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, run, mem_ready;
    logic [5:0] opcode, funct;
    logic       RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch;
    logic [2:0] ALUControl, state;
    logic       pc_en, ir_en, instr_done, illegal;

    int errors = 0;
    int checks = 0;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .MemtoReg   (MemtoReg),
        .Branch     (Branch),
        .ALUControl (ALUControl),
        .pc_en      (pc_en),
        .ir_en      (ir_en),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    // Instruction classes: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 illegal
    function automatic int classify(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00)
            return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                    fn == 6'h25 || fn == 6'h2A) ? 0 : 5;
        if (op == 6'h23) return 1;
        if (op == 6'h2B) return 2;
        if (op == 6'h04) return 3;
        if (op == 6'h08) return 4;
        return 5;
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20:   return 3'b010;
                6'h22:   return 3'b110;
                6'h24:   return 3'b000;
                6'h25:   return 3'b001;
                6'h2A:   return 3'b111;
                default: return 3'b000;
            endcase
        end
        if (op == 6'h04) return 3'b110;
        return 3'b010;
    endfunction

    // {state, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch,
    //  ALUControl, pc_en, ir_en, instr_done, illegal}
    function automatic logic [16:0] expect_vec(int cls, logic [2:0] alu, int s,
                                               bit last, bit run_b);
        logic busy, rd, rw, as, mw, mr, m2r, br;
        logic [2:0] a;
        busy = (s == 2 || s == 3 || s == 4);
        rd   = busy && cls == 0;
        rw   = (s == 4);
        as   = busy && (cls == 1 || cls == 2 || cls == 4);
        mw   = (s == 3) && cls == 2;
        mr   = (cls == 1) && (s == 3 || s == 4);
        m2r  = busy && cls == 1;
        br   = (s == 2) && cls == 3;
        a    = busy ? alu : 3'b000;
        return {3'(s), rd, rw, as, mw, mr, m2r, br, a,
                last, (s == 0) && run_b, last, s == 5};
    endfunction

    function automatic logic [16:0] observed();
        return {state, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg,
                Branch, ALUControl, pc_en, ir_en, instr_done, illegal};
    endfunction

    // Runs one instruction after `idle` run=0 cycles; w = extra MEM wait cycles.
    task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn,
                             int w, int idle);
        int seq[$];
        int cls, weff, mem_idx, n;
        logic [2:0] alu;
        logic [16:0] exp_v, act_v;
        cls  = classify(op, fn);
        alu  = alu_of(op, fn);
        weff = WAIT_EN ? w : 0;
        seq.push_back(0);
        seq.push_back(1);
        if (cls == 5) begin
            seq.push_back(5);
        end else begin
            seq.push_back(2);
            if (cls == 1 || cls == 2)
                for (int j = 0; j <= weff; j++) seq.push_back(3);
            if (cls == 0 || cls == 1 || cls == 4) seq.push_back(4);
        end
        n = seq.size();

        for (int k = 0; k < idle; k++) begin
            run       = 1'b0;
            opcode    = 6'($urandom);
            mem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            act_v = observed();
            if (act_v !== 17'h0)
                $display("FAIL %s idle%0d: got %h want %h", name, k, act_v, 17'h0);
            if (act_v !== 17'h0) errors++;
            @(posedge clk); #1;
        end

        opcode  = op;
        funct   = fn;
        mem_idx = 0;
        for (int i = 0; i < n; i++) begin
            run = (i == 0) ? 1'b1 : 1'($urandom);
            if (seq[i] == 3 && WAIT_EN) begin
                mem_ready = (mem_idx == weff);
                mem_idx++;
            end else begin
                mem_ready = 1'($urandom);
            end
            @(negedge clk);
            checks++;
            exp_v = expect_vec(cls, alu, seq[i], i == n - 1, run);
            act_v = observed();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s op=%h fn=%h cyc%0d: got %h want %h",
                         name, op, fn, i, act_v, exp_v);
            end
            @(posedge clk); #1;
        end
        $display("txn %s op=%h fn=%h cycles=%0d", name, op, fn, n);
    endtask

    task automatic test_reset();
        logic [16:0] act_v;
        reset  = 1'b1;
        run    = 1'b1;
        opcode = 6'h23;
        funct  = 6'h00;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        act_v = observed();
        if (act_v !== 17'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", act_v, 17'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            act_v = observed();
            if (act_v !== 17'h0) begin
                errors++;
                $display("FAIL run_low_hold%0d: got %h want %h", k, act_v, 17'h0);
            end
            @(posedge clk); #1;
        end
        $display("txn reset_and_run_low");
    endtask

    task automatic test_add();
        run_instr("add", 6'h00, 6'h20, 0, 0);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait", 6'h23, 6'($urandom), 3, 0);
    endtask

    task automatic test_beq();
        run_instr("beq", 6'h04, 6'($urandom), 0, 1);
    endtask

    task automatic test_illegal();
        run_instr("ill_op3f", 6'h3F, 6'h20, 0, 0);
        run_instr("ill_fn01", 6'h00, 6'h01, 0, 0);
    endtask

    task automatic test_alu_ops();
        run_instr("sub",  6'h00, 6'h22, 0, 0);
        run_instr("and",  6'h00, 6'h24, 0, 0);
        run_instr("or",   6'h00, 6'h25, 0, 0);
        run_instr("slt",  6'h00, 6'h2A, 0, 0);
        run_instr("addi", 6'h08, 6'h3F, 0, 0);
        run_instr("sw",   6'h2B, 6'h00, 2, 0);
        run_instr("lw",   6'h23, 6'h11, 0, 0);
    endtask

    task automatic test_sw_reset();
        logic [16:0] act_v;
        logic [3:0]  strobes;
        opcode    = 6'h2B;
        funct     = 6'h00;
        run       = 1'b1;
        mem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({state, MemWrite} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL sw_in_mem: got state=%0d MemWrite=%b want state=3 MemWrite=1",
                     state, MemWrite);
        end
        reset = 1'b1;
        #1;
        checks++;
        strobes = {MemWrite, RegWrite, pc_en, instr_done};
        if (strobes !== 4'b0) begin
            errors++;
            $display("FAIL sw_reset_cycle: got strobes=%b want 0000", strobes);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            act_v = observed();
            if (act_v !== 17'h0) begin
                errors++;
                $display("FAIL sw_after_reset%0d: got %h want %h", k, act_v, 17'h0);
            end
            @(posedge clk); #1;
        end
        $display("txn sw_reset_in_mem");
    endtask

    task automatic test_random();
        logic [5:0] legal_ops [5];
        logic [5:0] legal_fns [5];
        logic [5:0] op, fn;
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
        legal_fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int t = 0; t < 40; t++) begin
            op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 4)] : 6'($urandom);
            fn = ($urandom_range(0, 9) < 8) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr("rand", op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_lw",  6'h23, 6'h00, 1, 0);
        run_instr("b2b_sw",  6'h2B, 6'h00, 0, 0);
        run_instr("b2b_beq", 6'h04, 6'h00, 0, 0);
        run_instr("b2b_add", 6'h00, 6'h20, 0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_alu_ops();
        test_sw_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
